seg_scan_encoder: RTL and testbench



---
 rtl/seg_pkg.sv | 37 +++
 rtl/seg_encode.sv | 41 ++++
 rtl/seg_scan_encoder.sv | 173 +++++++++++++++++
 tb/tb_seg_scan_encoder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan encoder: glyph patterns, segment
// bit positions and the frame FSM state type.
package seg_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  // Glyphs with the decimal point clear; bit7=a ... bit1=g, bit0=dp
  localparam logic [7:0] SEG_0 = 8'hFC;
  localparam logic [7:0] SEG_1 = 8'h60;
  localparam logic [7:0] SEG_2 = 8'hDA;
  localparam logic [7:0] SEG_3 = 8'hF2;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'hB6;
  localparam logic [7:0] SEG_6 = 8'hBE;
  localparam logic [7:0] SEG_7 = 8'hE0;
  localparam logic [7:0] SEG_8 = 8'hFE;
  localparam logic [7:0] SEG_9 = 8'hF6;
  localparam logic [7:0] SEG_A_GLYPH = 8'hEE;
  localparam logic [7:0] SEG_B_GLYPH = 8'h3E;
  localparam logic [7:0] SEG_C_GLYPH = 8'h9C;
  localparam logic [7:0] SEG_D_GLYPH = 8'h7A;
  localparam logic [7:0] SEG_E_GLYPH = 8'h9E;
  localparam logic [7:0] SEG_F_GLYPH = 8'h8E;

  typedef enum logic {
    COLLECT = 1'b0,
    PUBLISH = 1'b1
  } state_t;

endpackage

// File: rtl/seg_encode.sv
// Combinational inverse of the hex-to-7-segment decoder: segment pattern to
// hex code, with an error flag for non-glyphs and the decimal point passed through.
module seg_encode
  import seg_pkg::*;
(
  input  logic [7:0] seg,
  output logic [3:0] code,
  output logic       err,
  output logic       dp
);

  logic [7:0] glyph;

  // The dp bit is masked off so a lit decimal point never disturbs the match
  always_comb begin
    glyph = {seg[7:1], 1'b0};
    code  = 4'h0;
    err   = 1'b0;
    dp    = seg[SEG_DP];
    case (glyph)
      SEG_0:       code = 4'h0;
      SEG_1:       code = 4'h1;
      SEG_2:       code = 4'h2;
      SEG_3:       code = 4'h3;
      SEG_4:       code = 4'h4;
      SEG_5:       code = 4'h5;
      SEG_6:       code = 4'h6;
      SEG_7:       code = 4'h7;
      SEG_8:       code = 4'h8;
      SEG_9:       code = 4'h9;
      SEG_A_GLYPH: code = 4'hA;
      SEG_B_GLYPH: code = 4'hB;
      SEG_C_GLYPH: code = 4'hC;
      SEG_D_GLYPH: code = 4'hD;
      SEG_E_GLYPH: code = 4'hE;
      SEG_F_GLYPH: code = 4'hF;
      default:     err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_encoder.sv
// Samples a multiplexed 7-segment bus, debounces each digit and publishes whole
// frames over valid/ready. Define SEG_OVERRUN_CNT_EN to add the dropped-frame counter.
module seg_scan_encoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3,
  parameter int CNT_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   com_in,
  output logic [4*NUM_DIGITS-1:0] out_data,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic [NUM_DIGITS-1:0]   out_dp,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef SEG_OVERRUN_CNT_EN
  ,
  output logic [7:0]              overrun_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [7:0]            seg_q;
  logic [NUM_DIGITS-1:0] com_q;
  logic                  one_hot;

  logic [3:0] enc_code;
  logic       enc_err;
  logic       enc_dp;

  logic [NUM_DIGITS-1:0][7:0]       last;
  logic [NUM_DIGITS-1:0][CNT_W-1:0] cnt;
  logic [NUM_DIGITS-1:0]            seen;
  logic [NUM_DIGITS-1:0][3:0]       sh_code;
  logic [NUM_DIGITS-1:0]            sh_err;
  logic [NUM_DIGITS-1:0]            sh_dp;

  logic [NUM_DIGITS-1:0] hit;
  logic [NUM_DIGITS-1:0] same;
  logic [NUM_DIGITS-1:0] commit;

  state_t state;
  state_t state_next;
  logic   publish;
  logic   slot_free;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q <= '0;
      com_q <= '0;
    end else begin
      seg_q <= seg_in;
      com_q <= com_in;
    end
  end

  assign one_hot   = (com_q != '0) && ((com_q & (com_q - 1'b1)) == '0);
  assign slot_free = !out_valid || out_ready;

  seg_encode u_encode (
    .seg  (seg_q),
    .code (enc_code),
    .err  (enc_err),
    .dp   (enc_dp)
  );

  // A commit landing in the publish cycle is discarded along with the counters
  always_comb begin
    hit    = '0;
    same   = '0;
    commit = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      hit[d]    = one_hot && com_q[d];
      same[d]   = (seg_q == last[d]);
      commit[d] = hit[d] && same[d] && (cnt[d] == CNT_PRE) && !publish;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last    <= '0;
      cnt     <= '0;
      seen    <= '0;
      sh_code <= '0;
      sh_err  <= '0;
      sh_dp   <= '0;
    end else begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (hit[d] && !same[d]) begin
          last[d] <= seg_q;
        end
        if (publish) begin
          cnt[d] <= '0;
        end else if (hit[d]) begin
          if (!same[d]) begin
            cnt[d] <= CNT_ONE;
          end else if (cnt[d] != CNT_MAX) begin
            cnt[d] <= cnt[d] + CNT_ONE;
          end
        end
        if (commit[d]) begin
          sh_code[d] <= enc_code;
          sh_err[d]  <= enc_err;
          sh_dp[d]   <= enc_dp;
        end
      end
      if (publish) begin
        seen <= '0;
      end else begin
        seen <= seen | commit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    publish    = 1'b0;
    case (state)
      COLLECT: begin
        if (&seen) begin
          state_next = PUBLISH;
        end
      end
      PUBLISH: begin
        publish    = 1'b1;
        state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  // A publish that finds the slot occupied leaves the held frame untouched
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_err   <= '0;
      out_dp    <= '0;
      out_valid <= 1'b0;
    end else if (publish && slot_free) begin
      out_data  <= sh_code;
      out_err   <= sh_err;
      out_dp    <= sh_dp;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SEG_OVERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_cnt <= '0;
    end else if (publish && !slot_free && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seg_scan_encoder.sv
// Directed self-checking bench for seg_scan_encoder; honours SEG_OVERRUN_CNT_EN.
module tb_seg_scan_encoder;

  localparam int NUM_DIGITS = 4;

  logic                    clk;
  logic                    rst;
  logic [7:0]              seg_in;
  logic [NUM_DIGITS-1:0]   com_in;
  logic [4*NUM_DIGITS-1:0] out_data;
  logic [NUM_DIGITS-1:0]   out_err;
  logic [NUM_DIGITS-1:0]   out_dp;
  logic                    out_valid;
  logic                    out_ready;
`ifdef SEG_OVERRUN_CNT_EN
  logic [7:0]              overrun_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit got;

  seg_scan_encoder #(
    .NUM_DIGITS (NUM_DIGITS),
    .STABLE_CNT (3),
    .CNT_W      (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .com_in    (com_in),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_dp    (out_dp),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SEG_OVERRUN_CNT_EN
    ,
    .overrun_cnt (overrun_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic show(input int d, input logic [7:0] p, input int n);
    com_in = NUM_DIGITS'(1) << d;
    seg_in = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    com_in = '0;
    seg_in = 8'h00;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int max, output bit found);
    found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      if (out_valid) found = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic count_valid(input int n, output int seen_n);
    seen_n = 0;
    for (int i = 0; i < n; i++) begin
      if (out_valid) seen_n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int nv;
    rst       = 1'b0;
    seg_in    = 8'h00;
    com_in    = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(out_valid), 32'h0);
    check("reset_data", 32'(out_data), 32'h0);
    check("reset_err", 32'(out_err), 32'h0);
    check("reset_dp", 32'(out_dp), 32'h0);
`ifdef SEG_OVERRUN_CNT_EN
    check("reset_overrun", 32'(overrun_cnt), 32'h0);
`endif
    rst = 1'b1;
    @(negedge clk);

    // Basic frame 1,2,3,4
    show(0, 8'h60, 3); show(1, 8'hDA, 3); show(2, 8'hF2, 3); show(3, 8'h66, 3);
    idle(0);
    wait_valid(20, got);
    check("t1_valid", 32'(got), 32'h1);
    check("t1_data", 32'(out_data), 32'h4321);
    check("t1_err", 32'(out_err), 32'h0);
    check("t1_dp", 32'(out_dp), 32'h0);
    @(negedge clk);
    check("t1_pulse_end", 32'(out_valid), 32'h0);
    idle(5);

    // Blank digit and dp digit
    show(0, 8'hFC, 3); show(1, 8'hF7, 3); show(2, 8'h00, 3); show(3, 8'h66, 3);
    idle(0);
    wait_valid(20, got);
    check("t2_valid", 32'(got), 32'h1);
    check("t2_data", 32'(out_data), 32'h4090);
    check("t2_err", 32'(out_err), 32'h4);
    check("t2_dp", 32'(out_dp), 32'h2);
    idle(5);

    // Digit0 too short: no frame until it is shown long enough
    show(0, 8'hFC, 2); show(1, 8'h60, 3); show(2, 8'hDA, 3); show(3, 8'hF2, 3);
    idle(0);
    count_valid(10, nv);
    check("t3_no_frame", 32'(nv), 32'h0);
    show(0, 8'hFC, 3);
    idle(0);
    wait_valid(20, got);
    check("t3_valid", 32'(got), 32'h1);
    check("t3_data", 32'(out_data), 32'h3210);
    idle(5);

    // Back-pressure: second frame dropped, first frame held
    out_ready = 1'b0;
    show(0, 8'h66, 3); show(1, 8'hB6, 3); show(2, 8'hBE, 3); show(3, 8'hE0, 3);
    idle(0);
    wait_valid(20, got);
    check("t4_valid", 32'(got), 32'h1);
    check("t4_data", 32'(out_data), 32'h7654);
    show(0, 8'hFE, 3); show(1, 8'hF6, 3); show(2, 8'hEE, 3); show(3, 8'h3E, 3);
    idle(10);
    check("t4_held_valid", 32'(out_valid), 32'h1);
    check("t4_held_data", 32'(out_data), 32'h7654);
`ifdef SEG_OVERRUN_CNT_EN
    check("t4_overrun", 32'(overrun_cnt), 32'h1);
`endif
    out_ready = 1'b1;
    check("t4_valid_before_accept", 32'(out_valid), 32'h1);
    @(negedge clk);
    check("t4_valid_after_accept", 32'(out_valid), 32'h0);
    idle(5);

    // Multi-hot select mid-frame is ignored
    show(0, 8'h9C, 3); show(1, 8'h7A, 3);
    com_in = 4'b0011; seg_in = 8'h9E;
    repeat (10) @(negedge clk);
    show(2, 8'h9E, 3); show(3, 8'h8E, 3);
    idle(0);
    wait_valid(20, got);
    check("t5_valid", 32'(got), 32'h1);
    check("t5_data", 32'(out_data), 32'hFEDC);
    check("t5_err", 32'(out_err), 32'h0);
    idle(5);

    // Reset mid-frame discards progress
    show(0, 8'hFC, 3); show(1, 8'h60, 3); show(2, 8'hDA, 3);
    idle(0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_reset_data", 32'(out_data), 32'h0);
    check("t6_reset_valid", 32'(out_valid), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    show(3, 8'hF2, 3);
    idle(0);
    count_valid(10, nv);
    check("t6_no_frame", 32'(nv), 32'h0);
    show(0, 8'hFC, 3); show(1, 8'h60, 3); show(2, 8'hDA, 3); show(3, 8'hF2, 3);
    idle(0);
    wait_valid(20, got);
    check("t6_valid", 32'(got), 32'h1);
    check("t6_data", 32'(out_data), 32'h3210);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
